// File: rtl/sys_seq.sv
// sys_seq: single-clock tile sequencer for the convolution datapath.
//
// Per tile it loads weights one column at a time, streams feature vectors at
// a programmable step rate, drains the systolic skew, hands off to pooling
// and reports completion. Every downstream block runs on i_clk and is driven
// by the enable strobes produced here rather than by derived clocks.
//
// Ports
//   i_clk, i_nrst       clock, synchronous active-low reset
//   i_start             tile start pulse (accepted only in IDLE)
//   i_weight_dim        weight beats per column
//   i_num_filter        active columns
//   i_map_len           feature vectors per tile
//   i_rate_div          step period is i_rate_div + 1 cycles
//   i_w_valid/o_w_ready weight beat handshake
//   i_f_valid/o_f_ready feature vector handshake
//   i_pool_done         pooling complete pulse
//   o_weight_load_en    one-hot column write strobe
//   o_feed_en           input_array shift enable
//   o_sys_en            systolic step enable
//   o_col_out_en        per-column output valid (registered)
//   o_conv_finish       last systolic output pulse, also starts pooling
//   o_busy              high outside IDLE
//   o_done              tile-complete pulse
//   o_err               configuration error pulse
//
// Build option
//   SYS_SEQ_CFG_CHECK_EN  when defined, a bad configuration at start raises
//                         o_err and the tile is refused; otherwise fields are
//                         clamped into range and every start is accepted.
module sys_seq #(
  parameter int unsigned ROW   = 25,
  parameter int unsigned COL   = 32,
  parameter int unsigned MAP_W = 10,
  parameter int unsigned DIV_W = 4
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_start,
  input  logic [4:0]       i_weight_dim,
  input  logic [5:0]       i_num_filter,
  input  logic [MAP_W-1:0] i_map_len,
  input  logic [DIV_W-1:0] i_rate_div,
  input  logic             i_w_valid,
  output logic             o_w_ready,
  input  logic             i_f_valid,
  output logic             o_f_ready,
  input  logic             i_pool_done,
  output logic [COL-1:0]   o_weight_load_en,
  output logic             o_feed_en,
  output logic             o_sys_en,
  output logic [COL-1:0]   o_col_out_en,
  output logic             o_conv_finish,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  // Step counter width, plus one guard bit so range compares never wrap.
  localparam int unsigned SW = $clog2(2**MAP_W + ROW + COL);
  localparam int unsigned EW = SW + 1;

  typedef enum logic [2:0] {StIdle, StLoadW, StStream, StDrain, StPool} state_e;

  state_e r_state, w_state_nxt;

  // Latched tile configuration
  logic [4:0]       r_wd;
  logic [5:0]       r_nf;
  logic [MAP_W-1:0] r_ml;
  logic [DIV_W-1:0] r_rd;

  // Counters and registered strobes
  logic [4:0]       r_wcnt;
  logic [5:0]       r_col;
  logic [DIV_W-1:0] r_div_cnt;
  logic [SW-1:0]    r_step;
  logic [COL-1:0]   r_col_out_en;
  logic             r_conv_finish;
  logic             r_done;
  logic             r_err;

  logic             w_idle;
  logic             w_start_ok;
  logic             w_err_set;
  logic [4:0]       w_wd_lat;
  logic [5:0]       w_nf_lat;
  logic [MAP_W-1:0] w_ml_lat;

  logic             w_step_pt;
  logic             w_col_end;
  logic             w_beat;
  logic             w_feed;
  logic             w_drain_step;
  logic             w_drain_last;
  logic             w_sys_en;
  logic             w_pool_acc;
  logic             w_w_ready;
  logic             w_f_ready;
  logic [EW-1:0]    w_s_ext;
  logic [EW-1:0]    w_ml_ext;
  logic [EW-1:0]    w_total_m1;
  logic [COL-1:0]   w_col_hit;

  assign w_idle = (r_state == StIdle);

`ifdef SYS_SEQ_CFG_CHECK_EN
  logic w_cfg_bad;
  assign w_cfg_bad  = (i_num_filter == 6'd0) || (i_num_filter > 6'(COL)) ||
                      (i_weight_dim == 5'd0) || (i_map_len == '0);
  assign w_start_ok = i_start && w_idle && !w_cfg_bad;
  assign w_err_set  = i_start && w_idle && w_cfg_bad;
  assign w_wd_lat   = i_weight_dim;
  assign w_nf_lat   = i_num_filter;
  assign w_ml_lat   = i_map_len;
`else
  assign w_start_ok = i_start && w_idle;
  assign w_err_set  = 1'b0;
  assign w_wd_lat   = (i_weight_dim == 5'd0) ? 5'd1 : i_weight_dim;
  assign w_nf_lat   = (i_num_filter == 6'd0)     ? 6'd1 :
                      (i_num_filter > 6'(COL))   ? 6'(COL) : i_num_filter;
  assign w_ml_lat   = (i_map_len == '0) ? MAP_W'(1) : i_map_len;
`endif

  assign w_step_pt  = (r_div_cnt == r_rd);
  assign w_col_end  = (r_wcnt == r_wd - 5'd1);
  assign w_s_ext    = {1'b0, r_step};
  assign w_ml_ext   = EW'(r_ml);
  // Index of the final step: ml + ROW + nf - 2 steps in total.
  assign w_total_m1 = w_ml_ext + EW'(ROW) + EW'(r_nf) - EW'(3);
  assign w_sys_en   = w_feed | w_drain_step;

  // conv_finish occupies the first POOL cycle, so pool_done is only honoured after it.
  assign w_pool_acc = (r_state == StPool) && i_pool_done && !r_conv_finish && !r_done;

  // Column c is valid after step s when c < nf and ROW-1+c <= s < ROW-1+c+ml.
  for (genvar c = 0; c < COL; c++) begin : g_col
    localparam logic [EW-1:0] Lo = EW'(ROW - 1 + c);
    assign w_col_hit[c] = ({1'b0, r_nf} > 7'(c)) && (w_s_ext >= Lo) &&
                          (w_s_ext < Lo + w_ml_ext);
    assign o_weight_load_en[c] = w_beat && (r_col == 6'(c));
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_w_ready    = 1'b0;
    w_f_ready    = 1'b0;
    w_beat       = 1'b0;
    w_feed       = 1'b0;
    w_drain_step = 1'b0;
    w_drain_last = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_start_ok) w_state_nxt = StLoadW;
      end
      StLoadW: begin
        w_w_ready = 1'b1;
        w_beat    = i_w_valid;
        if (i_w_valid && w_col_end && (r_col == r_nf - 6'd1)) w_state_nxt = StStream;
      end
      StStream: begin
        w_f_ready = w_step_pt;
        w_feed    = w_step_pt && i_f_valid;
        if (w_step_pt && i_f_valid && (w_s_ext == w_ml_ext - EW'(1))) w_state_nxt = StDrain;
      end
      StDrain: begin
        w_drain_step = w_step_pt;
        w_drain_last = w_step_pt && (w_s_ext == w_total_m1);
        if (w_step_pt && (w_s_ext == w_total_m1)) w_state_nxt = StPool;
      end
      StPool: begin
        if (r_done) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_wd          <= '0;
      r_nf          <= '0;
      r_ml          <= '0;
      r_rd          <= '0;
      r_wcnt        <= '0;
      r_col         <= '0;
      r_div_cnt     <= '0;
      r_step        <= '0;
      r_col_out_en  <= '0;
      r_conv_finish <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_err         <= w_err_set;
      r_done        <= w_pool_acc;
      r_conv_finish <= w_drain_last;
      r_col_out_en  <= w_sys_en ? w_col_hit : '0;

      if (w_start_ok) begin
        r_wd   <= w_wd_lat;
        r_nf   <= w_nf_lat;
        r_ml   <= w_ml_lat;
        r_rd   <= i_rate_div;
        r_wcnt <= '0;
        r_col  <= '0;
        r_step <= '0;
      end

      if (w_beat) begin
        if (w_col_end) begin
          r_wcnt <= '0;
          r_col  <= r_col + 6'd1;
        end else begin
          r_wcnt <= r_wcnt + 5'd1;
        end
      end

      // Divider restarts on each step and on entry to STREAM/DRAIN; a stall
      // leaves it parked on the step point.
      if ((r_state == StStream) || (r_state == StDrain)) begin
        if ((w_state_nxt != r_state) || w_sys_en) begin
          r_div_cnt <= '0;
        end else if (!w_step_pt) begin
          r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
      end else begin
        r_div_cnt <= '0;
      end

      if (w_sys_en) r_step <= r_step + SW'(1);
    end
  end

  assign o_w_ready     = w_w_ready;
  assign o_f_ready     = w_f_ready;
  assign o_feed_en     = w_feed;
  assign o_sys_en      = w_sys_en;
  assign o_col_out_en  = r_col_out_en;
  assign o_conv_finish = r_conv_finish;
  assign o_busy        = !w_idle;
  assign o_done        = r_done;
  assign o_err         = r_err;

endmodule

// File: tb/tb_sys_seq.sv
// Directed bench for sys_seq with ROW=4, COL=4.
module tb_sys_seq;
  localparam int ROW = 4;
  localparam int COL = 4;

  logic       clk = 1'b0;
  logic       nrst, start, w_valid, f_valid, pool_done;
  logic [4:0] weight_dim;
  logic [5:0] num_filter;
  logic [9:0] map_len;
  logic [3:0] rate_div;
  logic       w_ready, f_ready, feed_en, sys_en, conv_finish, busy, done, err;
  logic [COL-1:0] wle, coe;

  int errors = 0;
  int checks = 0;

  // Per-cycle observations of the last run_tile call
  logic [3:0] a_wle[64], a_coe[64];
  logic a_wr[64], a_fr[64], a_feed[64], a_sys[64], a_fin[64], a_busy[64], a_done[64], a_err[64];

  sys_seq #(.ROW(ROW), .COL(COL), .MAP_W(10), .DIV_W(4)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_start(start),
    .i_weight_dim(weight_dim), .i_num_filter(num_filter), .i_map_len(map_len),
    .i_rate_div(rate_div), .i_w_valid(w_valid), .o_w_ready(w_ready),
    .i_f_valid(f_valid), .o_f_ready(f_ready), .i_pool_done(pool_done),
    .o_weight_load_en(wle), .o_feed_en(feed_en), .o_sys_en(sys_en),
    .o_col_out_en(coe), .o_conv_finish(conv_finish), .o_busy(busy),
    .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

  function automatic bit has(input int q[$], input int v);
    foreach (q[i]) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  // Runs ncyc cycles starting at posedge+1 with the DUT idle; cycle 0 carries start.
  task automatic run_tile(input int nf, input int wd, input int ml, input int rd,
                          input int ncyc, input int pool_cyc, input int gap_lo,
                          input int gap_hi, input int st2, input int st3, input int st4,
                          input int rst_cyc);
    for (int t = 0; t < ncyc; t++) begin
      start      = (t == 0) || (t == st2) || (t == st3) || (t == st4);
      num_filter = 6'(nf);
      weight_dim = 5'(wd);
      map_len    = 10'(ml);
      rate_div   = 4'(rd);
      w_valid    = 1'b1;
      f_valid    = !((t >= gap_lo) && (t <= gap_hi));
      pool_done  = (t == pool_cyc);
      nrst       = (t != rst_cyc);
      @(negedge clk);
      a_wle[t] = wle;     a_coe[t] = coe;     a_wr[t] = w_ready; a_fr[t] = f_ready;
      a_feed[t] = feed_en; a_sys[t] = sys_en; a_fin[t] = conv_finish;
      a_busy[t] = busy;    a_done[t] = done;  a_err[t] = err;
      @(posedge clk);
      #1;
    end
    start = 1'b0; pool_done = 1'b0; nrst = 1'b1;
  endtask

  task automatic test_reset;
    nrst = 1'b0; start = 1'b0; w_valid = 1'b0; f_valid = 1'b0; pool_done = 1'b0;
    weight_dim = '0; num_filter = '0; map_len = '0; rate_div = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, w_ready, f_ready, feed_en, sys_en, conv_finish, done, err} !== 8'h00) begin
      errors++;
      $display("FAIL reset_scalars: got=%b exp=00000000",
               {busy, w_ready, f_ready, feed_en, sys_en, conv_finish, done, err});
    end
    checks++;
    if ({wle, coe} !== 8'h00) begin
      errors++;
      $display("FAIL reset_vectors: wle=%b coe=%b exp=0000/0000", wle, coe);
    end
    nrst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // nf=2 wd=3 ml=5 rd=0: loads at cycles 1-6, steps 0-8 at cycles 7-15.
  task automatic test_basic;
    run_tile(2, 3, 5, 0, 24, 19, -1, -2, -1, -1, -1, -1);
    for (int t = 0; t < 24; t++) begin
      logic [3:0] ew, ec;
      ew = (t >= 1 && t <= 3) ? 4'b0001 : (t >= 4 && t <= 6) ? 4'b0010 : 4'b0000;
      ec = {2'b00, (t >= 12 && t <= 16), (t >= 11 && t <= 15)};
      checks++;
      if (a_wle[t] !== ew) begin
        errors++; $display("FAIL basic_wle t=%0d got=%b exp=%b", t, a_wle[t], ew);
      end
      checks++;
      if (a_coe[t] !== ec) begin
        errors++; $display("FAIL basic_coe t=%0d got=%b exp=%b", t, a_coe[t], ec);
      end
      checks++;
      if (a_feed[t] !== (t >= 7 && t <= 11)) begin
        errors++; $display("FAIL basic_feed t=%0d got=%b", t, a_feed[t]);
      end
      checks++;
      if (a_sys[t] !== (t >= 7 && t <= 15)) begin
        errors++; $display("FAIL basic_sys t=%0d got=%b", t, a_sys[t]);
      end
      checks++;
      if ({a_fin[t], a_done[t], a_busy[t], a_wr[t], a_err[t]} !==
          {t == 16, t == 20, (t >= 1 && t <= 20), (t >= 1 && t <= 6), 1'b0}) begin
        errors++;
        $display("FAIL basic_ctl t=%0d got fin/done/busy/wr/err=%b%b%b%b%b", t,
                 a_fin[t], a_done[t], a_busy[t], a_wr[t], a_err[t]);
      end
    end
  endtask

  // rd=2: steps every 3 cycles, first step at cycle 9, DRAIN steps from cycle 24.
  task automatic test_rate;
    int fr_c[$] = '{9, 12, 15, 18, 21};
    run_tile(2, 3, 5, 2, 42, 37, -1, -2, -1, -1, -1, -1);
    for (int t = 0; t < 42; t++) begin
      checks++;
      if (a_sys[t] !== (t >= 9 && t <= 33 && ((t - 9) % 3) == 0)) begin
        errors++; $display("FAIL rate_sys t=%0d got=%b", t, a_sys[t]);
      end
      checks++;
      if (a_fr[t] !== has(fr_c, t) || a_feed[t] !== has(fr_c, t)) begin
        errors++; $display("FAIL rate_fready t=%0d got fr=%b feed=%b", t, a_fr[t], a_feed[t]);
      end
      checks++;
      if ({a_fin[t], a_done[t]} !== {t == 34, t == 38}) begin
        errors++; $display("FAIL rate_fin_done t=%0d got=%b%b", t, a_fin[t], a_done[t]);
      end
    end
  endtask

  // rd=2 with f_valid low over cycles 12-15: the second step slips to cycle 16.
  task automatic test_stall;
    int sys_c[$]  = '{9, 16, 19, 22, 25, 28, 31, 34, 37};
    int fr_c[$]   = '{9, 12, 13, 14, 15, 16, 19, 22, 25};
    int feed_c[$] = '{9, 16, 19, 22, 25};
    int c0_c[$]   = '{23, 26, 29, 32, 35};
    int c1_c[$]   = '{26, 29, 32, 35, 38};
    int nsys;
    nsys = 0;
    run_tile(2, 3, 5, 2, 46, 41, 12, 15, -1, -1, -1, -1);
    for (int t = 0; t < 46; t++) begin
      logic [3:0] ec;
      ec = {2'b00, has(c1_c, t), has(c0_c, t)};
      if (a_sys[t] === 1'b1) nsys++;
      checks++;
      if (a_sys[t] !== has(sys_c, t)) begin
        errors++; $display("FAIL stall_sys t=%0d got=%b", t, a_sys[t]);
      end
      checks++;
      if (a_fr[t] !== has(fr_c, t) || a_feed[t] !== has(feed_c, t)) begin
        errors++; $display("FAIL stall_fready t=%0d got fr=%b feed=%b", t, a_fr[t], a_feed[t]);
      end
      checks++;
      if (a_coe[t] !== ec) begin
        errors++; $display("FAIL stall_coe t=%0d got=%b exp=%b", t, a_coe[t], ec);
      end
      checks++;
      if ({a_fin[t], a_done[t]} !== {t == 38, t == 42}) begin
        errors++; $display("FAIL stall_fin_done t=%0d got=%b%b", t, a_fin[t], a_done[t]);
      end
    end
    checks++;
    if (nsys !== 9) begin
      errors++; $display("FAIL stall_step_total: got=%0d exp=9", nsys);
    end
  endtask

  // Reset during DRAIN (cycle 13), then a clean tile.
  task automatic test_reset_mid;
    int nsys;
    run_tile(2, 3, 5, 0, 22, -1, -1, -2, -1, -1, -1, 13);
    checks++;
    if (a_busy[13] !== 1'b1 || a_sys[13] !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: got busy=%b sys=%b exp=1/1", a_busy[13], a_sys[13]);
    end
    for (int t = 14; t < 22; t++) begin
      checks++;
      if ({a_busy[t], a_wr[t], a_fr[t], a_feed[t], a_sys[t], a_fin[t], a_done[t], a_err[t],
           a_wle[t], a_coe[t]} !== 16'h0000) begin
        errors++;
        $display("FAIL rstmid_idle t=%0d got busy=%b sys=%b fin=%b wle=%b coe=%b exp all 0",
                 t, a_busy[t], a_sys[t], a_fin[t], a_wle[t], a_coe[t]);
      end
    end
    run_tile(2, 3, 5, 0, 24, 19, -1, -2, -1, -1, -1, -1);
    nsys = 0;
    for (int t = 0; t < 24; t++) begin
      if (a_sys[t] === 1'b1) nsys++;
      checks++;
      if ({a_fin[t], a_done[t], a_busy[t]} !== {t == 16, t == 20, (t >= 1 && t <= 20)}) begin
        errors++;
        $display("FAIL rstmid_retile t=%0d got fin/done/busy=%b%b%b", t, a_fin[t], a_done[t],
                 a_busy[t]);
      end
    end
    checks++;
    if (nsys !== 9) begin
      errors++; $display("FAIL rstmid_step_total: got=%0d exp=9", nsys);
    end
  endtask

  // Extra starts in STREAM (9), POOL (18) and the done cycle (20) are ignored.
  task automatic test_start_ignored;
    int nsys;
    nsys = 0;
    run_tile(2, 3, 5, 0, 24, 19, -1, -2, 9, 18, 20, -1);
    for (int t = 0; t < 24; t++) begin
      if (a_sys[t] === 1'b1) nsys++;
      checks++;
      if ({a_sys[t], a_fin[t], a_done[t], a_busy[t], a_wr[t]} !==
          {(t >= 7 && t <= 15), t == 16, t == 20, (t >= 1 && t <= 20), (t >= 1 && t <= 6)}) begin
        errors++;
        $display("FAIL ign_start t=%0d got sys/fin/done/busy/wr=%b%b%b%b%b", t, a_sys[t],
                 a_fin[t], a_done[t], a_busy[t], a_wr[t]);
      end
    end
    checks++;
    if (nsys !== 9) begin
      errors++; $display("FAIL ign_step_total: got=%0d exp=9", nsys);
    end
  endtask

  // nf=5 exceeds COL=4.
  task automatic test_cfg;
`ifdef SYS_SEQ_CFG_CHECK_EN
    run_tile(5, 3, 5, 0, 6, -1, -1, -2, -1, -1, -1, -1);
    for (int t = 0; t < 6; t++) begin
      checks++;
      if ({a_err[t], a_busy[t], a_wr[t]} !== {t == 1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL cfg_err t=%0d got err/busy/wr=%b%b%b exp=%b00", t, a_err[t], a_busy[t],
                 a_wr[t], t == 1);
      end
    end
`else
    // Clamped to nf=4, wd=1, ml=1: 6 DRAIN steps at cycles 6-11.
    run_tile(5, 1, 1, 0, 18, 13, -1, -2, -1, -1, -1, -1);
    for (int t = 0; t < 18; t++) begin
      logic [3:0] ew;
      ew = (t >= 1 && t <= 4) ? 4'(1 << (t - 1)) : 4'b0000;
      checks++;
      if (a_wle[t] !== ew) begin
        errors++; $display("FAIL cfg_walk t=%0d got=%b exp=%b", t, a_wle[t], ew);
      end
      checks++;
      if ({a_fin[t], a_done[t], a_busy[t], a_err[t]} !==
          {t == 12, t == 14, (t >= 1 && t <= 14), 1'b0}) begin
        errors++;
        $display("FAIL cfg_clamp t=%0d got fin/done/busy/err=%b%b%b%b", t, a_fin[t], a_done[t],
                 a_busy[t], a_err[t]);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rate();
    test_stall();
    test_reset_mid();
    test_start_ignored();
    test_cfg();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
